// File: rtl/riscv_decode_stage_if.sv
// Fetch-to-decode handshake and decoded-instruction bus of riscv_decode_stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface riscv_decode_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_class;
  logic [2:0]      out_funct3;
  logic            out_alt;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_rd_we;
  logic [31:0]     out_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_funct3, out_alt,
           out_rs1, out_rs2, out_rd, out_rs1_used, out_rs2_used, out_rd_we,
           out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_funct3, out_alt,
           out_rs1, out_rs2, out_rd, out_rs1_used, out_rs2_used, out_rd_we,
           out_imm, out_illegal
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage: full decode of one instruction per handshake,
// two-entry (head + skid) output buffer, synchronous flush for redirects.
module riscv_decode_stage #(
  parameter int unsigned PC_W         = 32,
  parameter bit          ENABLE_ZICSR = 1'b1,
  parameter bit          ENABLE_FENCE = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  riscv_decode_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    cls_e            cls;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic [31:0]     imm;
  } entry_t;

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t      dec;
  entry_t      head, skid;
  logic        head_valid, skid_valid;
  logic        accept, pop;

  assign instr = bus.in_instr;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Flags and immediate are only set on legal paths, so illegal words leave them 0.
  always_comb begin
    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.cls      = CLS_ILLEGAL;
    dec.funct3   = f3;
    dec.alt      = instr[30];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    if (instr[1:0] == 2'b11) begin
      unique case (instr[6:2])
        5'b01101: begin dec.cls = CLS_LUI;   dec.imm = imm_u; dec.rd_we = 1'b1; end
        5'b00101: begin dec.cls = CLS_AUIPC; dec.imm = imm_u; dec.rd_we = 1'b1; end
        5'b11011: begin dec.cls = CLS_JAL;   dec.imm = imm_j; dec.rd_we = 1'b1; end
        5'b11001: if (f3 == 3'b000) begin
          dec.cls = CLS_JALR; dec.imm = imm_i; dec.rs1_used = 1'b1; dec.rd_we = 1'b1;
        end
        5'b11000: if (f3[2:1] != 2'b01) begin
          dec.cls = CLS_BRANCH; dec.imm = imm_b; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        end
        5'b00000: if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
          dec.cls = CLS_LOAD; dec.imm = imm_i; dec.rs1_used = 1'b1; dec.rd_we = 1'b1;
        end
        5'b01000: if (f3 <= 3'b010) begin
          dec.cls = CLS_STORE; dec.imm = imm_s; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        end
        5'b00100: if (!(f3 == 3'b001 && f7 != 7'b0000000) &&
                      !(f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
          dec.cls = CLS_OP_IMM; dec.imm = imm_i; dec.rs1_used = 1'b1; dec.rd_we = 1'b1;
        end
        5'b01100: if (f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.cls = CLS_OP; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.rd_we = 1'b1;
        end
        5'b11100: if (ENABLE_ZICSR) begin
          dec.cls = CLS_SYSTEM; dec.imm = imm_i; dec.rs1_used = !f3[2]; dec.rd_we = 1'b1;
        end
        5'b00011: if (ENABLE_FENCE) dec.cls = CLS_FENCE;
        default: ;
      endcase
    end
    if (dec.rd == 5'd0) dec.rd_we = 1'b0;
  end

  assign accept = bus.in_valid && !skid_valid;
  assign pop    = head_valid && bus.out_ready;

  // Skid only ever fills behind a valid head and always drains into the head first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head       <= '0;
      skid       <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        head       <= skid;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head       <= dec;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!head_valid) begin
        head       <= dec;
        head_valid <= 1'b1;
      end else begin
        skid       <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = !skid_valid;
  assign bus.out_valid    = head_valid;
  assign bus.out_pc       = head.pc;
  assign bus.out_class    = head.cls;
  assign bus.out_funct3   = head.funct3;
  assign bus.out_alt      = head.alt;
  assign bus.out_rs1      = head.rs1;
  assign bus.out_rs2      = head.rs2;
  assign bus.out_rd       = head.rd;
  assign bus.out_rs1_used = head.rs1_used;
  assign bus.out_rs2_used = head.rs2_used;
  assign bus.out_rd_we    = head.rd_we;
  assign bus.out_imm      = head.imm;
  assign bus.out_illegal  = (head.cls == CLS_ILLEGAL);

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed self-checking bench for riscv_decode_stage: reset, decode table,
// back-pressure ordering, flush, and parameter-disabled opcodes.
module tb_riscv_decode_stage;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  riscv_decode_stage_if #(.PC_W(32)) bus ();
  riscv_decode_stage_if #(.PC_W(32)) bus_nz ();

  riscv_decode_stage #(.PC_W(32), .ENABLE_ZICSR(1'b1), .ENABLE_FENCE(1'b1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus.slave)
  );

  riscv_decode_stage #(.PC_W(32), .ENABLE_ZICSR(1'b0), .ENABLE_FENCE(1'b0)) dut_nz (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus_nz.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_handshake: got valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
    n_checks++;
    if ({bus.out_class, bus.out_imm, bus.out_pc, bus.out_rd_we, bus.out_illegal} !== 70'd0) begin
      n_fail++; $display("FAIL reset_data: class=%0d imm=%h pc=%h rd_we=%b ill=%b want all 0",
                         bus.out_class, bus.out_imm, bus.out_pc, bus.out_rd_we, bus.out_illegal);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_decode_stream();
    logic [31:0] v_instr [14] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h0010006F,
                                  32'h123452B7, 32'h00000000, 32'h40001033, 32'h0000B003,
                                  32'h0000A003, 32'h00000073, 32'h0000000F, 32'h40005033,
                                  32'h00001067, 32'h02001013};
    logic [3:0]  v_cls [14]   = '{4'd7, 4'd6, 4'd4, 4'd2, 4'd0, 4'd15, 4'd15, 4'd15,
                                  4'd5, 4'd9, 4'd10, 4'd8, 4'd15, 4'd15};
    logic [31:0] v_imm [14]   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                  32'h12345000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h0, 32'h0};
    // {rs1_used, rs2_used, rd_we, illegal}
    logic [3:0]  v_flg [14]   = '{4'b1010, 4'b1100, 4'b1100, 4'b0000, 4'b0010, 4'b0001,
                                  4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b1100,
                                  4'b0001, 4'b0001};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      offer(v_instr[i], 32'h100 + 32'(i) * 4);
      tick();
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_pc} !== {2'b11, 32'h100 + 32'(i) * 4}) begin
        n_fail++; $display("FAIL stream_hs[%0d]: valid=%b ready=%b pc=%h want 1 1 %h", i,
                           bus.out_valid, bus.in_ready, bus.out_pc, 32'h100 + 32'(i) * 4);
      end
      n_checks++;
      if ({bus.out_class, bus.out_imm, bus.out_rs1_used, bus.out_rs2_used, bus.out_rd_we, bus.out_illegal}
          !== {v_cls[i], v_imm[i], v_flg[i]}) begin
        n_fail++; $display("FAIL decode[%0d] %h: class=%0d imm=%h flags=%b want class=%0d imm=%h flags=%b",
                           i, v_instr[i], bus.out_class, bus.out_imm,
                           {bus.out_rs1_used, bus.out_rs2_used, bus.out_rd_we, bus.out_illegal},
                           v_cls[i], v_imm[i], v_flg[i]);
      end
      if (i == 1) begin
        n_checks++;
        if ({bus.out_funct3, bus.out_alt, bus.out_rs1, bus.out_rs2, bus.out_rd} !== {3'd2, 1'b1, 5'd1, 5'd2, 5'd28}) begin
          n_fail++; $display("FAIL sw_fields: f3=%0d alt=%b rs1=%0d rs2=%0d rd=%0d want 2 1 1 2 28",
                             bus.out_funct3, bus.out_alt, bus.out_rs1, bus.out_rs2, bus.out_rd);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.out_rd !== 5'd5) begin
          n_fail++; $display("FAIL lui_rd: got %0d want 5", bus.out_rd);
        end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_disabled_opcodes();
    logic [31:0] words [2] = '{32'h00000073, 32'h0000000F};
    bus_nz.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_nz.in_valid = 1'b1;
      bus_nz.in_instr = words[i];
      bus_nz.in_pc    = 32'h40 + 32'(i);
      tick();
      n_checks++;
      if ({bus_nz.out_valid, bus_nz.out_class, bus_nz.out_illegal, bus_nz.out_rs1_used,
           bus_nz.out_rs2_used, bus_nz.out_rd_we, bus_nz.out_imm} !== {1'b1, 4'd15, 4'b1000, 32'h0}) begin
        n_fail++; $display("FAIL disabled[%h]: valid=%b class=%0d ill=%b flags=%b imm=%h want 1 15 1 000 0",
                           words[i], bus_nz.out_valid, bus_nz.out_class, bus_nz.out_illegal,
                           {bus_nz.out_rs1_used, bus_nz.out_rs2_used, bus_nz.out_rd_we}, bus_nz.out_imm);
      end
    end
    bus_nz.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    offer(32'hFFF00093, 32'hA0);
    tick();
    offer(32'hFE20AE23, 32'hB0);
    tick();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_pc} !== {2'b10, 32'hA0}) begin
      n_fail++; $display("FAIL bp_skid_full: valid=%b ready=%b pc=%h want 1 0 a0", bus.out_valid, bus.in_ready, bus.out_pc);
    end
    offer(32'hFE000CE3, 32'hC0);
    tick();
    n_checks++;
    if ({bus.in_ready, bus.out_pc, bus.out_class, bus.out_imm} !== {1'b0, 32'hA0, 4'd7, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL bp_stable: ready=%b pc=%h class=%0d imm=%h want 0 a0 7 ffffffff",
                         bus.in_ready, bus.out_pc, bus.out_class, bus.out_imm);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_pc, bus.out_class} !== {2'b11, 32'hB0, 4'd6}) begin
      n_fail++; $display("FAIL bp_order_b: valid=%b ready=%b pc=%h class=%0d want 1 1 b0 6",
                         bus.out_valid, bus.in_ready, bus.out_pc, bus.out_class);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_class} !== {1'b1, 32'hC0, 4'd4}) begin
      n_fail++; $display("FAIL bp_order_c: valid=%b pc=%h class=%0d want 1 c0 4", bus.out_valid, bus.out_pc, bus.out_class);
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: out_valid=%b pc=%h want 0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    offer(32'h0010006F, 32'hD0);
    tick();
    offer(32'h123452B7, 32'hD4);
    tick();
    offer(32'hFE20AE23, 32'hD8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_clear: valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_dropped: out_valid=%b pc=%h want 0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    offer(32'hFFF00093, 32'hE0);
    tick();
    offer(32'hFE20AE23, 32'hE4);
    tick();
    bus.in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_imm, bus.out_pc} !== {2'b01, 64'd0}) begin
      n_fail++; $display("FAIL midreset: valid=%b ready=%b imm=%h pc=%h want 0 1 0 0",
                         bus.out_valid, bus.in_ready, bus.out_imm, bus.out_pc);
    end
    @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    offer(32'h123452B7, 32'hF0);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL postreset_early: out_valid=%b want 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_class, bus.out_imm, bus.out_rd_we} !== {1'b1, 32'hF0, 4'd0, 32'h12345000, 1'b1}) begin
      n_fail++; $display("FAIL postreset_first: valid=%b pc=%h class=%0d imm=%h rd_we=%b want 1 f0 0 12345000 1",
                         bus.out_valid, bus.out_pc, bus.out_class, bus.out_imm, bus.out_rd_we);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    bus.in_valid = 1'b0;    bus.in_instr = '0;    bus.in_pc = '0;    bus.out_ready = 1'b1;
    bus_nz.in_valid = 1'b0; bus_nz.in_instr = '0; bus_nz.in_pc = '0; bus_nz.out_ready = 1'b1;
    test_reset();
    test_decode_stream();
    test_disabled_opcodes();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Registered, parametrised RV32I decode stage between the fetch stage and the register-file/execute stage. It accepts one instruction word plus PC per valid/ready handshake and fully decodes it: class, register indices, sign-extended immediate, and register-use flags. It also flags illegal encodings. A two-entry output buffer keeps full throughput under downstream back-pressure, and a synchronous flush supports branch redirects.

## Interface
- PC_W, 32, width of the program counter carried with each instruction
- ENABLE_ZICSR, 1, when 0, SYSTEM opcode (1110011) is decoded as illegal
- ENABLE_FENCE, 1, when 0, MISC-MEM opcode (0001111) is decoded as illegal
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered entries this cycle
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts
- out_pc  out  PC_W  PC of entry
- out_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM (0010011), 8 OP (0110011), 9 SYSTEM, 10 FENCE, 15 ILLEGAL
- out_funct3  out  3  instr[14:12]
- out_alt  out  1  instr[30] (SUB/SRA select)
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
- out_rs1_used, out_rs2_used  out  1 each  operand actually read
- out_rd_we  out  1  writes rd (forced 0 when rd==0)
- out_imm  out  32  format-selected immediate
- out_illegal  out  1  equals (out_class==15)

## Operation
- Immediates: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = {instr[31:12],12'b0}; J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
- Format selection: LUI/AUIPC use U; JAL uses J; JALR/LOAD/OP_IMM/SYSTEM use I; STORE uses S; BRANCH uses B; OP/FENCE/ILLEGAL output 0.
- Illegal when any of the following holds:
  - instr[1:0] != 11, or the opcode is not listed, or the opcode is disabled by a parameter;
  - JALR with funct3 != 000;
  - BRANCH with funct3 in {010, 011};
  - LOAD with funct3 in {011, 110, 111};
  - STORE with funct3 > 010;
  - OP with funct7 not in {0000000, 0100000}, or funct7 = 0100000 with funct3 not in {000, 101};
  - OP_IMM with funct3 = 001 and funct7 != 0, or funct3 = 101 and funct7 not in {0000000, 0100000}.
- Use flags:
  - rs1_used for JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM with funct3[2]=0.
  - rs2_used for BRANCH, STORE, OP.
  - rd_we for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, SYSTEM, and only when rd != 0.
  - All use flags are 0 when illegal.
- Buffer: two decoded entries, an output register (head) and a skid register, in FIFO order. in_ready = !skid_valid (registered, not derived from out_ready).
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Simultaneous accept and pop: the occupancy is unchanged and order is preserved.
- flush: both entries are invalidated and any same-cycle input is dropped. flush has priority over accept and pop.

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N (1 cycle).
- Throughput is 1 per cycle while out_ready=1.
- Back-pressure: when out_ready=0, one further instruction is absorbed into the skid register. in_ready falls the cycle after the skid fills and rises the cycle after the skid drains into the head.
- Reset: out_valid=0, in_ready=1, and every data output is 0, including out_class=0. Reset is honoured mid-transfer; all buffered entries are lost.
- Outputs come only from registers; there is no combinational path from the in_* signals to the out_* signals.
- Output data is held stable while out_valid && !out_ready.

## Test plan
- Reset with resetn=0 mid-stream -> out_valid=0, in_ready=1, out_imm=0 immediately; first instruction after release appears 1 cycle after acceptance.
- Stream addi x1,x0,-1 (0xFFF00093), sw x2,-4(x1) (0xFE20AE23), beq x0,x0,-8 (0xFE000CE3), jal x0,2048 (0x0010006F with imm check) -> classes 7,6,4,2; imm 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x00000800; rd_we 1,0,0,0 (jal rd=0).
- lui x5,0x12345 (0x123452B7) -> class 0, imm 0x12345000, rs1_used=0, rd_we=1, rd=5.
- Illegal words: 0x00000000, 0x40001033 (funct7=0100000 with funct3=001), 0x0000A003 (LOAD funct3=010 is legal; use 0x0000B003) and, with ENABLE_ZICSR=0, 0x00000073 -> class 15, out_illegal=1, all use flags 0.
- Hold out_ready=0 while offering 3 instructions -> two accepted, in_ready=0 on the third; outputs stable. Release -> order A,B,C delivered, no loss or duplication.
- Assert flush with two entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction is not delivered.
